uart_tx_fifo_param: RTL

Parametrised UART transmitter with an integrated synchronous FIFO. It generalises the team's fixed 8N1 transmitter in data width (5-9 bits), parity mode (none, even or odd), stop bits (1 or 2) and FIFO depth. Frames are exactly DIV clocks per bit, with no first-bit off-by-one. The block sits between any byte producer (command/response logic) and the board TX pin, and signals frame completion and busy.

---
 rtl/uart_tx_fifo_param_pkg.sv | 23 ++
 rtl/uart_tx_fifo_param_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared types and helpers for the parametrised UART transmitter and its FIFO.
package uart_tx_fifo_param_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } uart_tx_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input longint clk_in, input longint baud);
        return int'((clk_in + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Synchronous first-word fall-through FIFO, shared by the UART transmitter and receiver.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      data_count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             wrAccept;
    logic             rdAccept;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign wrAccept     = wr_en_i && !full_o;
    assign rdAccept     = rd_en_i && !empty_o;
    assign full_o       = (count_q == (AW + 1)'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign data_count_o = count_q;
    assign dout_o       = mem_q[rdPtr_q];

    // Storage array: written at the tail pointer, never reset.
    always_ff @(posedge clk_i) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wrAccept) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (rdAccept) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({wrAccept, rdAccept})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by an integrated FIFO; frames go out back-to-back.
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int      CLK_IN     = 100000000,
    parameter int      BAUD       = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16,
    parameter int      DIV        = calc_div(CLK_IN, BAUD)
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic                          wr_en_i,
    input  logic [DATA_BITS-1:0]          din_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   data_count_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          tx_done_o
);

    localparam int           CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
    localparam logic [3:0]   DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]   STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit           HAS_PARITY = (PARITY != PARITY_NONE);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadParams
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    uart_tx_state_t          state_q;
    logic [CW-1:0]           clkCnt_q;
    logic [3:0]              bitCnt_q;
    logic [DATA_BITS-1:0]    shift_q;
    logic                    parityBit_q;
    logic                    tx_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    fifoEmpty;
    logic                    fifoPop;
    logic [DATA_BITS-1:0]    fifoDout;
    logic                    clkLast;
    logic                    frameEnd;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .wr_en_i      (wr_en_i),
        .din_i        (din_i),
        .rd_en_i      (fifoPop),
        .dout_o       (fifoDout),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .data_count_o (data_count_o)
    );

    assign fifoEmpty = empty_o;
    assign clkLast   = (clkCnt_q == CNT_LAST);
    assign frameEnd  = (state_q == ST_STOP) && clkLast && (bitCnt_q == STOP_LAST);
    // The head word is taken when the line is idle or on the last clock of a frame.
    assign fifoPop   = !fifoEmpty && ((state_q == ST_IDLE) || frameEnd);

    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign tx_done_o = done_q;

    // Frame sequencer: every bit is held for DIV clocks, outputs are registered.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            clkCnt_q    <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parityBit_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    clkCnt_q <= '0;
                    bitCnt_q <= '0;
                    if (!fifoEmpty) begin
                        shift_q     <= fifoDout;
                        parityBit_q <= (PARITY == PARITY_ODD) ? ~^fifoDout : ^fifoDout;
                        state_q     <= ST_START;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (clkLast) begin
                        clkCnt_q <= '0;
                        state_q  <= ST_DATA;
                        tx_q     <= shift_q[0];
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (clkLast) begin
                        clkCnt_q <= '0;
                        if (bitCnt_q == DATA_LAST) begin
                            bitCnt_q <= '0;
                            if (HAS_PARITY) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parityBit_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (clkLast) begin
                        clkCnt_q <= '0;
                        state_q  <= ST_STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (clkCnt_q == CNT_PRE && bitCnt_q == STOP_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (clkLast) begin
                        clkCnt_q <= '0;
                        if (bitCnt_q == STOP_LAST) begin
                            bitCnt_q <= '0;
                            if (!fifoEmpty) begin
                                shift_q     <= fifoDout;
                                parityBit_q <= (PARITY == PARITY_ODD) ? ~^fifoDout : ^fifoDout;
                                state_q     <= ST_START;
                                tx_q        <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    clkCnt_q <= '0;
                    bitCnt_q <= '0;
                end
            endcase
        end
    end

endmodule
